// File: rtl/sram_access_arbiter.sv
// Two-port arbiter for the shared off-chip SRAM: round-robin grant, fixed-length
// strobe window, registered read capture and a one-cycle Done pulse per access.
module sram_access_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Wdata0,
  input  logic [DATA_W-1:0] Wdata1,
  output logic              Done0,
  output logic              Done1,
  output logic [DATA_W-1:0] Rdata,
  output logic              Busy,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  output logic              Data_OE,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_CE,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic [1:0]        Dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                port_q;
  logic                we_q;
  logic                prio_q;
  logic                mask0_q;
  logic                mask1_q;
  logic                done0_q;
  logic                done1_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                data_oe_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic                ub_n_q;
  logic                lb_n_q;

  // Handshake: a requester raises ReqN with WeN/AddrN/WdataN stable and keeps them
  // until DoneN pulses; a grant is final, so dropping ReqN afterwards cannot cancel it.
  // The served port is masked for one IDLE cycle so a late-dropped Req is not re-served.
  logic                elig0_d;
  logic                elig1_d;
  logic                grant_valid_d;
  logic                grant_port_d;
  logic                grant_we_d;
  logic [ADDR_W-1:0]   grant_addr_d;
  logic [DATA_W-1:0]   grant_wdata_d;

  always_comb begin
    elig0_d       = Req0 && !mask0_q;
    elig1_d       = Req1 && !mask1_q;
    grant_valid_d = elig0_d || elig1_d;
    grant_port_d  = (elig0_d && elig1_d) ? prio_q : elig1_d;
    grant_we_d    = grant_port_d ? We1 : We0;
    grant_addr_d  = grant_port_d ? Addr1 : Addr0;
    grant_wdata_d = grant_port_d ? Wdata1 : Wdata0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      prio_q    <= 1'b0;
      mask0_q   <= 1'b0;
      mask1_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_oe_q <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      mask0_q <= 1'b0;
      mask1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid_d) begin
            state_q   <= S_ACCESS;
            cnt_q     <= CNT_INIT;
            port_q    <= grant_port_d;
            we_q      <= grant_we_d;
            addr_q    <= grant_addr_d;
            wdata_q   <= grant_wdata_d;
            ce_n_q    <= 1'b0;
            ub_n_q    <= 1'b0;
            lb_n_q    <= 1'b0;
            oe_n_q    <= grant_we_d;
            we_n_q    <= !grant_we_d;
            data_oe_q <= grant_we_d;
          end
        end
        S_ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q   <= S_RECOVER;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            data_oe_q <= 1'b0;
            done0_q   <= !port_q;
            done1_q   <= port_q;
            // Strobes are still active during this last cycle, so the bus is valid.
            if (!we_q) begin
              rdata_q <= Data_from_SRAM;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RECOVER: begin
          state_q <= S_IDLE;
          ce_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          prio_q  <= !port_q;
          mask0_q <= !port_q;
          mask1_q <= port_q;
        end
        default: begin
          state_q   <= S_IDLE;
          ce_n_q    <= 1'b1;
          oe_n_q    <= 1'b1;
          we_n_q    <= 1'b1;
          ub_n_q    <= 1'b1;
          lb_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign Done0        = done0_q;
  assign Done1        = done1_q;
  assign Rdata        = rdata_q;
  assign Busy         = (state_q != S_IDLE);
  assign Mem_ADDR     = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign Data_OE      = data_oe_q;
  assign Mem_CE       = ce_n_q;
  assign Mem_OE       = oe_n_q;
  assign Mem_WE       = we_n_q;
  assign Mem_UB       = ub_n_q;
  assign Mem_LB       = lb_n_q;
  assign Dbg_state    = state_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: a WAIT_CYCLES=2 instance on a small SRAM
// model plus a WAIT_CYCLES=1 instance for the short-access case.
module tb_sram_access_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, busy, data_oe;
  logic [DW-1:0] rdata, data_to_sram, data_from_sram;
  logic [AW-1:0] mem_addr;
  logic          mem_ce, mem_oe, mem_we, mem_ub, mem_lb;
  logic [1:0]    dbg_state;

  logic          b_req0;
  logic [AW-1:0] b_addr0;
  logic          b_done0, b_done1, b_busy, b_data_oe;
  logic [DW-1:0] b_rdata, b_data_to_sram, b_data_from_sram;
  logic [AW-1:0] b_mem_addr;
  logic          b_mem_ce, b_mem_oe, b_mem_we, b_mem_ub, b_mem_lb;
  logic [1:0]    b_dbg_state;

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Reset(rst),
    .Req0(req0), .Req1(req1), .We0(we0), .We1(we1),
    .Addr0(addr0), .Addr1(addr1), .Wdata0(wdata0), .Wdata1(wdata1),
    .Done0(done0), .Done1(done1), .Rdata(rdata), .Busy(busy),
    .Mem_ADDR(mem_addr), .Data_to_SRAM(data_to_sram), .Data_OE(data_oe),
    .Data_from_SRAM(data_from_sram),
    .Mem_CE(mem_ce), .Mem_OE(mem_oe), .Mem_WE(mem_we), .Mem_UB(mem_ub), .Mem_LB(mem_lb),
    .Dbg_state(dbg_state)
  );

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut_w1 (
    .Clk(clk), .Reset(rst),
    .Req0(b_req0), .Req1(1'b0), .We0(1'b0), .We1(1'b0),
    .Addr0(b_addr0), .Addr1('0), .Wdata0('0), .Wdata1('0),
    .Done0(b_done0), .Done1(b_done1), .Rdata(b_rdata), .Busy(b_busy),
    .Mem_ADDR(b_mem_addr), .Data_to_SRAM(b_data_to_sram), .Data_OE(b_data_oe),
    .Data_from_SRAM(b_data_from_sram),
    .Mem_CE(b_mem_ce), .Mem_OE(b_mem_oe), .Mem_WE(b_mem_we), .Mem_UB(b_mem_ub), .Mem_LB(b_mem_lb),
    .Dbg_state(b_dbg_state)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) mem[8'h42] <= 16'hBEEF;
    else if (!mem_ce && !mem_we && data_oe) mem[mem_addr[7:0]] <= data_to_sram;
  end
  assign data_from_sram   = (!mem_ce && !mem_oe) ? mem[mem_addr[7:0]] : 16'h0000;
  assign b_data_from_sram = (!b_mem_ce && !b_mem_oe) ? 16'hC0DE : 16'h0000;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic tr_ce[32], tr_oe[32], tr_we[32], tr_doe[32], tr_d0[32], tr_d1[32], tr_busy[32];
  logic [AW-1:0] tr_addr[32];
  logic [DW-1:0] tr_wd[32];

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Samples cycles 0..n-1 at the falling edge; optionally drops Req after its Done.
  task automatic capture(input int n, input bit auto_drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_ce[i] = mem_ce; tr_oe[i] = mem_oe; tr_we[i] = mem_we; tr_doe[i] = data_oe;
      tr_d0[i] = done0; tr_d1[i] = done1; tr_busy[i] = busy;
      tr_addr[i] = mem_addr; tr_wd[i] = data_to_sram;
      if (auto_drop) begin
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
      end
    end
  endtask

  task automatic start_req(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    logic b_oe[8], b_d0[8];
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; b_addr0 = '0;

    // reset values
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; b_req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_strobes", {mem_ce, mem_oe, mem_we, mem_ub, mem_lb}, 5'b11111);
    check_eq("rst_doe_done_busy", {data_oe, done0, done1, busy}, 4'b0000);
    check_eq("rst_rdata", rdata, 16'h0000);
    check_eq("rst_addr", mem_addr, 20'h0);
    check_eq("rst_wdata", data_to_sram, 16'h0000);

    // T1 single port-0 read of 0x00042
    @(posedge clk); #1 rst = 1'b0;
    start_req(1'b0, 1'b0, 20'h00042, 16'h0000);
    capture(6, 1'b1);
    check_eq("t1_oe", {tr_oe[0], tr_oe[1], tr_oe[2], tr_oe[3]}, 4'b1001);
    check_eq("t1_ce_we", {tr_ce[1], tr_we[1], tr_doe[1]}, 3'b010);
    check_eq("t1_addr", tr_addr[1], 20'h00042);
    check_eq("t1_done0", {tr_d0[2], tr_d0[3], tr_d0[4]}, 3'b010);
    check_eq("t1_busy", {tr_busy[0], tr_busy[1], tr_busy[3], tr_busy[4]}, 4'b0110);
    check_eq("t1_rdata", rdata, 16'hBEEF);

    // T2 port-1 write of 0x1234 to 0x00010, then port-0 read back
    @(posedge clk); #1;
    start_req(1'b1, 1'b1, 20'h00010, 16'h1234);
    capture(5, 1'b1);
    check_eq("t2_we", {tr_we[0], tr_we[1], tr_we[2], tr_we[3]}, 4'b1001);
    check_eq("t2_doe", {tr_doe[0], tr_doe[1], tr_doe[2], tr_doe[3]}, 4'b0110);
    check_eq("t2_oe", {tr_oe[1], tr_oe[2]}, 2'b11);
    check_eq("t2_wdata", tr_wd[1], 16'h1234);
    check_eq("t2_done", {tr_d1[3], tr_d1[4], tr_d0[3]}, 3'b100);
    check_eq("t2_rdata_kept", rdata, 16'hBEEF);
    @(posedge clk); #1;
    start_req(1'b0, 1'b0, 20'h00010, 16'h0000);
    capture(5, 1'b1);
    check_eq("t2_rb_done0", tr_d0[3], 1'b1);
    check_eq("t2_rb_rdata", rdata, 16'h1234);

    // T3 both ports requesting after reset, then rotated priority
    do_reset();
    start_req(1'b0, 1'b0, 20'h00042, 16'h0000);
    start_req(1'b1, 1'b0, 20'h00010, 16'h0000);
    capture(10, 1'b1);
    check_eq("t3a_first", {tr_d0[3], tr_d1[3]}, 2'b10);
    check_eq("t3a_second", {tr_d0[7], tr_d1[7]}, 2'b01);
    check_eq("t3a_rdata", rdata, 16'h1234);
    @(posedge clk); #1;
    start_req(1'b0, 1'b0, 20'h00042, 16'h0000);
    capture(5, 1'b1);
    check_eq("t3b_solo", tr_d0[3], 1'b1);
    @(posedge clk); #1;
    start_req(1'b0, 1'b0, 20'h00042, 16'h0000);
    start_req(1'b1, 1'b0, 20'h00010, 16'h0000);
    capture(10, 1'b1);
    check_eq("t3c_first", {tr_d0[3], tr_d1[3]}, 2'b01);
    check_eq("t3c_second", {tr_d0[7], tr_d1[7]}, 2'b10);
    check_eq("t3c_rdata", rdata, 16'hBEEF);

    // T4 Req0 held through two accesses
    do_reset();
    start_req(1'b0, 1'b0, 20'h00042, 16'h0000);
    capture(10, 1'b0);
    req0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) cnt += int'(tr_d0[i]);
    check_eq("t4_done_count", cnt, 2);
    check_eq("t4_done_cycles", {tr_d0[3], tr_d0[4], tr_d0[8]}, 3'b101);
    check_eq("t4_gap_oe", {tr_oe[4], tr_oe[5], tr_oe[6], tr_oe[7]}, 4'b1100);
    check_eq("t4_gap_busy", {tr_busy[4], tr_busy[5], tr_busy[6]}, 3'b001);

    // T5 reset during cycle 2 of a port-1 write
    do_reset();
    start_req(1'b1, 1'b1, 20'h00020, 16'h5555);
    repeat (3) @(negedge clk);
    check_eq("t5_c2_we", {mem_we, data_oe}, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_c3_strobes", {mem_ce, mem_oe, mem_we, mem_ub, mem_lb}, 5'b11111);
    check_eq("t5_c3_doe_busy_done", {data_oe, busy, done1}, 3'b000);
    rst = 1'b0; req1 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt += int'(done1);
    end
    check_eq("t5_no_done1", cnt, 0);

    // T6 WAIT_CYCLES=1 read
    do_reset();
    b_req0 = 1'b1; b_addr0 = 20'h00005;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_oe[i] = b_mem_oe; b_d0[i] = b_done0;
      if (b_done0) b_req0 = 1'b0;
    end
    check_eq("t6_oe", {b_oe[0], b_oe[1], b_oe[2]}, 3'b101);
    check_eq("t6_done0", {b_d0[1], b_d0[2], b_d0[3]}, 3'b010);
    check_eq("t6_rdata", b_rdata, 16'hC0DE);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
